tt_sweep_checker: RTL and testbench

Parametrised exhaustive truth-table sweeper and checker for combinational blocks. Drives every input combination of an N_IN-input unit under test, holds each vector for DWELL clocks to settle, samples the N_OUT-bit response, and compares it against a packed expected table. The block is synthesizable and sits beside the unit under test, either in a bench or on-board. Each sweep reports the mismatch count, the first failing vector and a pass flag; binary or Gray ordering and single or continuous sweeps are selectable.

---
 rtl/tt_sweep_checker.sv | 212 +++++++++++++++++++++
 tb/tb_tt_sweep_checker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: drives every input vector of a combinational unit and checks its response
// against a packed expected table, reporting the mismatch count, the first failure and a pass flag.
// Latency: DWELL*2^N_IN cycles per sweep. There is no backpressure; start is ignored while busy.
module tt_sweep_checker #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 3,
  parameter int DWELL = 4,
  parameter int ERR_W = 8,
  parameter logic [(N_OUT<<N_IN)-1:0] EXPECTED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             gray,
  input  logic             loop,
  input  logic [N_OUT-1:0] dut_out,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_vec,
  output logic [N_OUT-1:0] fail_got
);

  // The dwell counter needs at least one bit, even when DWELL=1 and it never leaves zero.
  localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [N_IN-1:0]   IDX_LAST = '1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t state_q, state_d;

  logic             gray_q, gray_d;
  logic             loop_q, loop_d;
  logic             stop_q, stop_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [N_IN-1:0]  fail_vec_q, fail_vec_d;
  logic [N_OUT-1:0] fail_got_q, fail_got_d;
  logic             sweep_err_q, sweep_err_d;

  logic             accept;
  logic             sample;
  logic             sweep_end;
  logic             stop_pend;
  logic             mismatch;
  logic [N_OUT-1:0] exp_resp;

  // Sweep position i maps to the applied vector: identity, or reflected-binary Gray code.
  function automatic logic [N_IN-1:0] order_f(input logic [N_IN-1:0] i, input logic g);
    return g ? (i ^ (i >> 1)) : i;
  endfunction

  assign accept    = (state_q == S_IDLE) && start;
  assign sample    = (state_q == S_RUN) && (cnt_q == CNT_LAST);
  assign sweep_end = sample && (idx_q == IDX_LAST);
  // A stop raised on the final sample edge itself still ends a continuous run.
  assign stop_pend = stop_q | stop;
  assign mismatch  = sample && (dut_out != exp_resp);

  // Look up the expected response for the vector currently applied.
  always_comb begin
    exp_resp = '0;
    for (int v = 0; v < (1 << N_IN); v++) begin
      if (stim_q == N_IN'(v)) begin
        exp_resp = EXPECTED[v*N_OUT +: N_OUT];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a sweep always runs to completion before returning to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (sweep_end && (!loop_q || stop_pend)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == S_RUN);
  end

  // Datapath next-state: vector stepping, sampling, error accounting and end-of-sweep reporting.
  always_comb begin
    gray_d       = gray_q;
    loop_d       = loop_q;
    stop_d       = stop_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    stim_d       = stim_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_got_d   = fail_got_q;
    sweep_err_d  = sweep_err_q;

    if (accept) begin
      gray_d       = gray;
      loop_d       = loop;
      stop_d       = 1'b0;
      idx_d        = '0;
      cnt_d        = '0;
      stim_d       = order_f('0, gray);
      pass_d       = 1'b0;
      err_d        = '0;
      fail_valid_d = 1'b0;
      fail_vec_d   = '0;
      fail_got_d   = '0;
      sweep_err_d  = 1'b0;
    end else if (state_q == S_RUN) begin
      if (stop) stop_d = 1'b1;

      if (!sample) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = '0;

        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          // Only the first mismatch since start is recorded.
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = stim_q;
            fail_got_d   = dut_out;
          end
        end

        if (!sweep_end) begin
          idx_d       = idx_q + 1'b1;
          stim_d      = order_f(idx_q + 1'b1, gray_q);
          sweep_err_d = sweep_err_q | mismatch;
        end else begin
          done_d      = 1'b1;
          pass_d      = !(sweep_err_q | mismatch);
          sweep_err_d = 1'b0;
          if (!loop_q || stop_pend) begin
            // Going idle: stim keeps the last vector applied.
            stop_d = 1'b0;
          end else begin
            idx_d  = '0;
            stim_d = order_f('0, gray_q);
          end
        end
      end
    end
  end

  // Datapath registers; reset clears every reported value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_q       <= 1'b0;
      loop_q       <= 1'b0;
      stop_q       <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      stim_q       <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_got_q   <= '0;
      sweep_err_q  <= 1'b0;
    end else begin
      gray_q       <= gray_d;
      loop_q       <= loop_d;
      stop_q       <= stop_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      stim_q       <= stim_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_got_q   <= fail_got_d;
      sweep_err_q  <= sweep_err_d;
    end
  end

  assign stim       = stim_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign fail_got   = fail_got_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: a behavioural 3-in/3-out unit with injectable per-vector faults,
// a main checker (DWELL=4) and a second checker (DWELL=1, ERR_W=2) for saturation.
module tb_tt_sweep_checker;

  function automatic logic [2:0] beh(input logic [2:0] x);
    return x * 3'd3 + 3'd5;
  endfunction

  function automatic logic [23:0] build_exp();
    logic [23:0] t;
    t = '0;
    for (int v = 0; v < 8; v++) t[v*3 +: 3] = beh(3'(v));
    return t;
  endfunction

  localparam logic [23:0] EXP = build_exp();

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main checker
  logic       start, stop, gray, lp;
  logic [2:0] dut_out, stim, fail_vec, fail_got;
  logic       busy, done, pass, fail_valid;
  logic [7:0] err_count;
  logic [2:0] fmask [8];

  always_comb dut_out = beh(stim) ^ fmask[stim];

  tt_sweep_checker #(.N_IN(3), .N_OUT(3), .DWELL(4), .ERR_W(8), .EXPECTED(EXP)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .gray(gray), .loop(lp),
    .dut_out(dut_out), .stim(stim), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec), .fail_got(fail_got)
  );

  // saturation checker: every vector wrong
  logic       s_start;
  logic [2:0] s_dut_out, s_stim, s_fvec, s_fgot;
  logic       s_busy, s_done, s_pass, s_fv;
  logic [1:0] s_err;

  always_comb s_dut_out = beh(s_stim) ^ 3'b111;

  tt_sweep_checker #(.N_IN(3), .N_OUT(3), .DWELL(1), .ERR_W(2), .EXPECTED(EXP)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .stop(1'b0), .gray(1'b0), .loop(1'b0),
    .dut_out(s_dut_out), .stim(s_stim), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .fail_valid(s_fv), .fail_vec(s_fvec), .fail_got(s_fgot)
  );

  int n_checks = 0;
  int n_errs   = 0;

  logic [2:0] gray_tab [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  function automatic logic [2:0] ord(input int j, input logic g);
    return g ? gray_tab[j] : 3'(j);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({stim, busy, done, pass, err_count, fail_valid, fail_vec, fail_got} !== 23'd0) begin
      n_errs++;
      $display("FAIL reset_main: got busy=%b done=%b pass=%b err=%0d fv=%b stim=%0d, want all zero",
               busy, done, pass, err_count, fail_valid, stim);
    end
    n_checks++;
    if ({s_stim, s_busy, s_done, s_pass, s_err, s_fv, s_fvec, s_fgot} !== 17'd0) begin
      n_errs++;
      $display("FAIL reset_sat: got busy=%b err=%0d fv=%b, want all zero", s_busy, s_err, s_fv);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, err_count} !== 10'd0) begin
      n_errs++;
      $display("FAIL idle_after_reset: busy=%b done=%b err=%0d, want 0", busy, done, err_count);
    end
  endtask

  // One single-mode sweep using the current fault masks; called right at a negedge.
  task automatic test_single_sweep(input logic g, input string name);
    int         exp_err;
    logic       exp_fv;
    logic [2:0] exp_vec, exp_got, v, exp_stim;
    exp_err = 0; exp_fv = 1'b0; exp_vec = '0; exp_got = '0;
    for (int j = 0; j < 8; j++) begin
      v = ord(j, g);
      if (fmask[v] != 3'd0) begin
        exp_err++;
        if (!exp_fv) begin
          exp_fv = 1'b1; exp_vec = v; exp_got = beh(v) ^ fmask[v];
        end
      end
    end
    gray = g; lp = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy, stim} !== {1'b1, 3'd0}) begin
      n_errs++;
      $display("FAIL %s_first: busy=%b stim=%0d, want busy=1 stim=0", name, busy, stim);
    end
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      exp_stim = (k < 32) ? ord(k / 4, g) : ord(7, g);
      n_checks++;
      if (stim !== exp_stim) begin
        n_errs++;
        $display("FAIL %s_stim cycle %0d: got %0d want %0d", name, k, stim, exp_stim);
      end
      n_checks++;
      if (done !== (k == 32)) begin
        n_errs++;
        $display("FAIL %s_done cycle %0d: got %b want %b", name, k, done, (k == 32));
      end
    end
    n_checks++;
    if ({busy, pass, err_count, fail_valid, fail_vec, fail_got} !==
        {1'b0, (exp_err == 0), 8'(exp_err), exp_fv, exp_vec, exp_got}) begin
      n_errs++;
      $display("FAIL %s_result: busy=%b pass=%b err=%0d fv=%b vec=%0d got=%0d, want busy=0 pass=%b err=%0d fv=%b vec=%0d got=%0d",
               name, busy, pass, err_count, fail_valid, fail_vec, fail_got,
               (exp_err == 0), exp_err, exp_fv, exp_vec, exp_got);
    end
  endtask

  task automatic test_continuous();
    logic [2:0] exp_stim;
    logic       exp_done;
    for (int i = 0; i < 8; i++) fmask[i] = 3'd0;
    fmask[2] = 3'b001;
    gray = 1'b0; lp = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      exp_done = (k == 32) || (k == 64) || (k == 96) || (k == 128);
      exp_stim = (k < 128) ? 3'((k % 32) / 4) : 3'd7;
      n_checks++;
      if ({stim, done, busy} !== {exp_stim, exp_done, (k < 128)}) begin
        n_errs++;
        $display("FAIL cont_step cycle %0d: stim=%0d done=%b busy=%b, want %0d %b %b",
                 k, stim, done, busy, exp_stim, exp_done, (k < 128));
      end
      if (exp_done) begin
        n_checks++;
        if ({err_count, pass} !== {8'(k / 32), 1'b0}) begin
          n_errs++;
          $display("FAIL cont_done cycle %0d: err=%0d pass=%b, want err=%0d pass=0",
                   k, err_count, pass, k / 32);
        end
      end
      stop = (k == 99);
    end
    n_checks++;
    if ({busy, err_count, fail_valid, fail_vec, fail_got} !==
        {1'b0, 8'd4, 1'b1, 3'd2, beh(3'd2) ^ 3'b001}) begin
      n_errs++;
      $display("FAIL cont_final: busy=%b err=%0d fv=%b vec=%0d got=%0d, want 0 4 1 2 %0d",
               busy, err_count, fail_valid, fail_vec, fail_got, beh(3'd2) ^ 3'b001);
    end
    lp = 1'b0; stop = 1'b0;
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < 8; i++) fmask[i] = 3'd0;
    gray = 1'b0; lp = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      n_checks++;
      if ({stim, done} !== {((k < 32) ? 3'(k / 4) : 3'd7), (k == 32)}) begin
        n_errs++;
        $display("FAIL busy_start cycle %0d: stim=%0d done=%b", k, stim, done);
      end
      start = (k == 10);
      gray  = (k == 10);
    end
    n_checks++;
    if ({busy, pass, err_count} !== {1'b0, 1'b1, 8'd0}) begin
      n_errs++;
      $display("FAIL busy_start_result: busy=%b pass=%b err=%0d, want 0 1 0", busy, pass, err_count);
    end
  endtask

  task automatic test_reset_midsweep();
    for (int i = 0; i < 8; i++) fmask[i] = 3'd0;
    fmask[1] = 3'b100;
    gray = 1'b0; lp = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    n_checks++;
    if ({stim, busy, fail_valid} !== {3'd4, 1'b1, 1'b1}) begin
      n_errs++;
      $display("FAIL mid_pre: stim=%0d busy=%b fv=%b, want 4 1 1", stim, busy, fail_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({stim, busy, done, pass, err_count, fail_valid, fail_vec, fail_got} !== 23'd0) begin
      n_errs++;
      $display("FAIL mid_reset: stim=%0d busy=%b err=%0d fv=%b, want all zero", stim, busy, err_count, fail_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_checks++;
      if ({done, busy} !== 2'b00) begin
        n_errs++;
        $display("FAIL mid_after cycle %0d: done=%b busy=%b, want 0 0", k, done, busy);
      end
    end
  endtask

  task automatic test_saturation();
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n_checks++;
    if ({s_busy, s_stim} !== {1'b1, 3'd0}) begin
      n_errs++;
      $display("FAIL sat_first: busy=%b stim=%0d, want 1 0", s_busy, s_stim);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({s_stim, s_done, s_err} !== {((k < 8) ? 3'(k) : 3'd7), (k == 8), ((k < 3) ? 2'(k) : 2'd3)}) begin
        n_errs++;
        $display("FAIL sat_step cycle %0d: stim=%0d done=%b err=%0d", k, s_stim, s_done, s_err);
      end
    end
    n_checks++;
    if ({s_busy, s_pass, s_fv, s_fvec, s_fgot} !== {1'b0, 1'b0, 1'b1, 3'd0, beh(3'd0) ^ 3'b111}) begin
      n_errs++;
      $display("FAIL sat_result: busy=%b pass=%b fv=%b vec=%0d got=%0d, want 0 0 1 0 %0d",
               s_busy, s_pass, s_fv, s_fvec, s_fgot, beh(3'd0) ^ 3'b111);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; gray = 1'b0; lp = 1'b0; s_start = 1'b0;
    for (int i = 0; i < 8; i++) fmask[i] = 3'd0;
    repeat (2) @(negedge clk);
    test_reset();

    test_single_sweep(1'b0, "clean");
    fmask[5] = 3'b001;
    test_single_sweep(1'b0, "fault5");
    fmask[5] = 3'b000;
    fmask[6] = 3'b010;
    test_single_sweep(1'b1, "gray6");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++)
        fmask[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      test_single_sweep(1'($urandom_range(0, 1)), "rand");
    end

    test_continuous();
    test_start_while_busy();
    test_reset_midsweep();
    test_saturation();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
